// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per cycle, LSB digit first, over N = WIDTH/DIGIT cycles.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic             acc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT:0]   dsum;
   logic [WIDTH-1:0] work_nxt;
   logic             c_msb;
   logic             last;

   always_comb begin
      dsum = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
           + {{DIGIT{1'b0}}, carry_q};
      work_nxt = {dsum[DIGIT-1:0], work_q[WIDTH-1:DIGIT]};
      // Carry into the top bit of this digit, recovered from its sum bit
      c_msb = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ dsum[DIGIT-1];
      last  = (cnt_q == CW'(N - 1));
   end

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      work_d  = work_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               opa_d   = acc ? sum_q : a;
               opb_d   = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               work_d  = '0;
            end
         end
         RUN: begin
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            work_d  = work_nxt;
            carry_d = dsum[DIGIT];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
               state_d = DONE;
               sum_d   = work_nxt;
               cout_d  = dsum[DIGIT];
               ovf_d   = c_msb ^ dsum[DIGIT];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder (WIDTH=16, DIGIT=4).
module tb_digit_serial_adder;

   localparam int W = 16;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic         acc = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .acc   (acc),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [W-1:0] es,
                          input logic ec, input logic ev);
      chk({name, " sum"}, {16'h0, sum}, {16'h0, es});
      chk({name, " cout"}, {31'h0, cout}, {31'h0, ec});
      chk({name, " ovf"}, {31'h0, ovf}, {31'h0, ev});
   endtask

   // One operation with full cycle-by-cycle timing checks; poke pulses
   // start during RUN to confirm it is ignored.
   task automatic run_op(input string name, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic is,
                         input logic iacc, input logic [W-1:0] es,
                         input logic ec, input logic ev, input bit poke);
      @(negedge clk);
      a = ia; b = ib; sub = is; acc = iacc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom); acc = 1'($urandom);
      chk({name, " busy@1"}, {31'h0, busy}, 32'h1);
      chk({name, " done@1"}, {31'h0, done}, 32'h0);
      for (int k = 1; k < N; k++) begin
         if (poke) start = 1'b1;
         @(posedge clk); #1;
         chk({name, " busy run"}, {31'h0, busy}, 32'h1);
         chk({name, " done run"}, {31'h0, done}, 32'h0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, " done"}, {31'h0, done}, 32'h1);
      chk({name, " busy@done"}, {31'h0, busy}, 32'h0);
      chk_out(name, es, ec, ev);
      @(posedge clk); #1;
      chk({name, " done pulse"}, {31'h0, done}, 32'h0);
      chk({name, " idle busy"}, {31'h0, busy}, 32'h0);
      chk_out({name, " hold"}, es, ec, ev);
      @(posedge clk); #1;
      chk({name, " no restart"}, {31'h0, busy | done}, 32'h0);
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vt[3] = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vt[4] = '{16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[6] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};
      vt[7] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

      reset = 1'b1;
      #12;
      chk("rst busy", {31'h0, busy}, 32'h0);
      chk("rst done", {31'h0, done}, 32'h0);
      chk_out("rst", 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post rst idle", {31'h0, busy | done}, 32'h0);
      chk_out("post rst", 16'h0000, 1'b0, 1'b0);

      run_op("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0,
             16'h2233, 1'b0, 1'b0, 1'b0);
      run_op("acc", 16'hAAAA, 16'h0001, 1'b0, 1'b1,
             16'h2234, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sub,
                1'b0, vt[i].s, vt[i].c, vt[i].v, 1'b0);
      end

      // Abort on the second RUN cycle, from a nonzero previous sum
      run_op("pre", 16'h1000, 16'h0234, 1'b0, 1'b0,
             16'h1234, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      a = 16'h1111; b = 16'h1111; sub = 1'b0; acc = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("abort busy", {31'h0, busy}, 32'h0);
      chk("abort done", {31'h0, done}, 32'h0);
      chk_out("abort", 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < N + 2; k++) begin
         @(posedge clk); #1;
         chk("abort quiet", {31'h0, busy | done}, 32'h0);
      end
      chk_out("abort hold", 16'h0000, 1'b0, 1'b0);

      run_op("after", 16'h0003, 16'h0004, 1'b0, 1'b0,
             16'h0007, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
